// File: rtl/modinv_helper_store_pkg.sv
// rtl/modinv_helper_store_pkg.sv - shared constants, state encoding and clog2 for the store helper
package modinv_helper_store_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_COPY = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/modinv_helper_store_addsub.sv
// rtl/modinv_helper_store_addsub.sv - 32-bit add-with-carry and carry flop with init/enable
module modinv_helper_store_addsub
  import modinv_helper_store_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              ce,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum,
  output logic              c_out
);

  logic              carry;
  logic [WORD_W:0]   total;

  assign total = {1'b0, a} + {1'b0, b} + (WORD_W + 1)'(carry);
  assign sum   = total[WORD_W-1:0];
  assign c_out = total[WORD_W];

  // Carry rests at 1 so a subtract (a + ~b + 1) is ready as soon as init fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b1;
    end else if (init) begin
      carry <= 1'b1;
    end else if (ce) begin
      carry <= c_out;
    end
  end

endmodule

// File: rtl/modinv_helper_store.sv
// rtl/modinv_helper_store.sv - reduces buffer s (< 2q) by one conditional subtract of q into memory x
module modinv_helper_store
  import modinv_helper_store_pkg::*;
#(
  parameter int OPERAND_NUM_WORDS = 8,
  parameter int OPERAND_ADDR_BITS = 3,
  parameter int BUFFER_NUM_WORDS  = 9,
  parameter int BUFFER_ADDR_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  output logic                         rdy,
  output logic [BUFFER_ADDR_BITS-1:0]  s_addr,
  input  logic [WORD_W-1:0]            s_din,
  output logic [OPERAND_ADDR_BITS-1:0] q_addr,
  input  logic [WORD_W-1:0]            q_din,
  output logic [OPERAND_ADDR_BITS-1:0] x_addr,
  output logic                         x_wren,
  output logic [WORD_W-1:0]            x_dout
);

  localparam int CNT_W = clog2(OPERAND_NUM_WORDS + 2);
  localparam logic [CNT_W-1:0] CNT_N     = CNT_W'(OPERAND_NUM_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OPERAND_NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_QMAX  = CNT_W'(OPERAND_NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_SLAST = CNT_W'(BUFFER_NUM_WORDS - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx, cnt_m1;
  logic              calc_init, calc_ce;
  logic [WORD_W-1:0] qw, diff;
  logic              c_out;

  assign cnt_m1 = cnt - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  modinv_helper_store_addsub u_addsub (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (calc_init),
    .ce    (calc_ce),
    .a     (s_din),
    .b     (~qw),
    .sum   (diff),
    .c_out (c_out)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rdy       = 1'b0;
    s_addr    = '0;
    q_addr    = '0;
    x_addr    = '0;
    x_wren    = 1'b0;
    x_dout    = '0;
    calc_init = 1'b0;
    calc_ce   = 1'b0;
    qw        = q_din;
    case (state)
      ST_IDLE: begin
        rdy = 1'b1;
        if (ena) begin
          state_nx  = ST_SUB;
          cnt_nx    = '0;
          calc_init = 1'b1;
        end
      end
      ST_SUB: begin
        if (cnt <= CNT_SLAST) s_addr = BUFFER_ADDR_BITS'(cnt);
        q_addr = (cnt > CNT_QMAX) ? OPERAND_ADDR_BITS'(CNT_QMAX) : OPERAND_ADDR_BITS'(cnt);
        // The top s word has no q partner; it only absorbs the borrow.
        if (cnt == CNT_LAST) qw = '0;
        if (cnt != '0) begin
          calc_ce = 1'b1;
          if (cnt != CNT_LAST) begin
            x_wren = 1'b1;
            x_addr = OPERAND_ADDR_BITS'(cnt_m1);
            x_dout = diff;
          end
        end
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          state_nx = c_out ? ST_IDLE : ST_COPY;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_COPY: begin
        if (cnt < CNT_N) s_addr = BUFFER_ADDR_BITS'(cnt);
        if (cnt != '0) begin
          x_wren = 1'b1;
          x_addr = OPERAND_ADDR_BITS'(cnt_m1);
          x_dout = s_din;
        end
        if (cnt == CNT_N) begin
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_modinv_helper_store.sv
// tb/tb_modinv_helper_store.sv - scoreboard bench for the store helper
module tb_modinv_helper_store;

  localparam logic [255:0] P256 =
    256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] TOP_X =
    256'h00000000_FFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_00000000_00000004;

  logic        clk = 1'b0;
  logic        rst_n, ena, rdy, x_wren;
  logic [3:0]  s_addr;
  logic [2:0]  q_addr, x_addr;
  logic [31:0] s_din, q_din, x_dout;

  always #5 clk = ~clk;

  modinv_helper_store #(
    .OPERAND_NUM_WORDS(8), .OPERAND_ADDR_BITS(3), .BUFFER_NUM_WORDS(9), .BUFFER_ADDR_BITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rdy(rdy),
    .s_addr(s_addr), .s_din(s_din), .q_addr(q_addr), .q_din(q_din),
    .x_addr(x_addr), .x_wren(x_wren), .x_dout(x_dout)
  );

  logic [31:0] s_mem [0:8];
  logic [31:0] q_mem [0:7];
  logic [31:0] x_mem [0:7];

  always @(posedge clk) begin
    s_din <= (s_addr < 4'd9) ? s_mem[s_addr] : 32'hDEADBEEF;
    q_din <= q_mem[q_addr];
    if (x_wren) x_mem[x_addr] <= x_dout;
  end

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  bit  sb_on  = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n && !rdy) check("s_addr_range", 256'(s_addr <= 4'd8), 256'd1);
    if (rst_n && x_wren) begin
      wr_cnt++;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write", x_addr, x_dout);
        end else begin
          exp_e = exp_q.pop_front();
          check("x_write", 256'({x_addr, x_dout}), 256'({exp_e.addr, exp_e.data}));
        end
      end
    end
  end

  task automatic run_op(input string name, input logic [287:0] s_val, input logic [255:0] q_val,
                        input logic [255:0] exp_x, input int exp_lat, input int exp_wr,
                        input int hold);
    logic [287:0] diff;
    logic [255:0] x_act;
    int lat;
    for (int w = 0; w < 9; w++) s_mem[w] = s_val[32*w +: 32];
    for (int w = 0; w < 8; w++) q_mem[w] = q_val[32*w +: 32];
    diff = s_val - {32'd0, q_val};
    for (int w = 0; w < 8; w++) exp_q.push_back({3'(w), diff[32*w +: 32]});
    if (s_val < {32'd0, q_val})
      for (int w = 0; w < 8; w++) exp_q.push_back({3'(w), s_val[32*w +: 32]});
    wr_cnt = 0;
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (lat >= hold) ena = 1'b0;
    while (!rdy && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat >= hold) ena = 1'b0;
    end
    ena = 1'b0;
    check({name, "_latency"}, 256'(lat), 256'(exp_lat));
    check({name, "_writes"}, 256'(wr_cnt), 256'(exp_wr));
    check({name, "_queue_left"}, 256'(exp_q.size()), 256'd0);
    for (int w = 0; w < 8; w++) x_act[32*w +: 32] = x_mem[w];
    check({name, "_x"}, x_act, exp_x);
    repeat (2) @(negedge clk);
    check({name, "_idle_rdy"}, 256'(rdy), 256'd1);
    check({name, "_no_restart"}, 256'(wr_cnt), 256'(exp_wr));
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    for (int w = 0; w < 9; w++) s_mem[w] = '0;
    for (int w = 0; w < 8; w++) q_mem[w] = '0;
    repeat (2) @(negedge clk);
    check("reset_rdy", 256'(rdy), 256'd1);
    check("reset_wren", 256'(x_wren), 256'd0);
    check("reset_addrs", 256'({s_addr, q_addr, x_addr}), 256'd0);
    check("reset_dout", 256'(x_dout), 256'd0);
    rst_n = 1'b1;
    sb_on = 1'b1;

    run_op("q_plus_5",  {32'd0, P256} + 288'd5, P256, 256'd5,      11, 8,  1);
    run_op("five",      288'd5,                 P256, 256'd5,      20, 16, 1);
    run_op("s_eq_q",    {32'd0, P256},          P256, 256'd0,      11, 8,  1);
    run_op("q_minus_1", {32'd0, P256} - 288'd1, P256, P256 - 256'd1, 20, 16, 1);
    run_op("top_carry", {32'd1, 256'd3},        P256, TOP_X,       11, 8,  1);
    run_op("ena_held",  {32'd0, P256} + 288'd5, P256, 256'd5,      11, 8,  10);

    // Abort mid-SUB: the DUT must fall back to idle without waiting for a clock.
    sb_on = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_wren", 256'(x_wren), 256'd0);
    check("abort_rdy", 256'(rdy), 256'd1);
    check("abort_s_addr", 256'(s_addr), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    sb_on = 1'b1;

    run_op("after_reset", 288'd5, P256, 256'd5, 20, 16, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/modinv_helper_store.md
Name: modinv_helper_store

Overview:
- Final-stage helper of the modular invertor. Reads the (N+1)-word result buffer s (value < 2q) and writes the fully reduced N-word result x = s mod q into the operand-width output memory.
- Acts as the read-back counterpart to the buffer-initialisation helper. That helper loads the working buffers from operand memories; this block drains a working buffer back into an operand memory.
- Performs a single conditional subtraction of q as two counter-driven passes over synchronous 1-cycle-latency RAMs.

Parameters:
- OPERAND_NUM_WORDS, 8, number of 32-bit words in q and x (N).
- OPERAND_ADDR_BITS, 3, address width of q and x memories.
- BUFFER_NUM_WORDS, 9, number of 32-bit words in buffer s (must equal N+1).
- BUFFER_ADDR_BITS, 4, address width of s buffer.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  start strobe, sampled only while rdy=1
- rdy  out  1  high when idle; low while busy
- s_addr  out  BUFFER_ADDR_BITS  read address, s buffer
- s_din  in  32  s read data, valid one cycle after s_addr
- q_addr  out  OPERAND_ADDR_BITS  read address, modulus q
- q_din  in  32  q read data, valid one cycle after q_addr
- x_addr  out  OPERAND_ADDR_BITS  write address, result x
- x_wren  out  1  write enable, result x
- x_dout  out  32  write data, result x

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (async):
  - FSM goes to IDLE and counter to 0.
  - Outputs: rdy=1, x_wren=0, all addresses 0, x_dout=0, carry flop=1.
  - Reset mid-operation aborts immediately. x may hold partial data; no other cleanup.
- Memory reads: all are word-serial, LSW first.
- States: IDLE, SUB, COPY.
- IDLE:
  - rdy=1, x_wren=0, addresses 0.
  - ena=1 at a clock edge moves to SUB with cnt=0.
  - ena while busy is ignored; no queueing.
- SUB (N+2 cycles, cnt 0..N+1):
  - Reads: s_addr=cnt for cnt 0..N.
  - q_addr=min(cnt, N-1), so it never exceeds the address range. The q word for s index N is forced to 0.
  - Compute: at cnt k in 1..N+1, word w=k-1 gives {c_out, d} = s_din + ~qw + carry.
    - qw = q_din, or 0 when w=N.
    - carry starts at 1 on SUB entry and is updated with c_out every compute cycle.
  - Writes: at k in 1..N, x_wren=1, x_addr=w, x_dout=d. At k=N+1 (w=N) there is no write; only the final carry is captured.
  - Exit:
    - Final carry=1 (s>=q): go to IDLE. The difference already in x is the result.
    - Final carry=0 (borrow, s<q): go to COPY with cnt=0.
- COPY (N+1 cycles, cnt 0..N):
  - s_addr=cnt for cnt 0..N-1.
  - At cnt k in 1..N: x_wren=1, x_addr=k-1, x_dout=s_din.
  - Then go to IDLE.
- Latency, counted from the ena edge to rdy=1:
  - N+3 cycles without correction (11 for N=8).
  - 2N+4 cycles with correction (20 for N=8).
- Counters: wrap only through the state transition; no free-running wrap. Addresses return to 0 outside active cycles.
- Width rules: 32-bit word adds with a 1-bit carry; the carry is internal only. s[N] is only ever 0 or 1 by contract. The result is not checked for s>=2q; that input is undefined.
- rdy is combinational from state (IDLE).

Decomposition:
- Shared package (or include): clog2 function, state encodings, word width constant 32.
- Counter width: clog2(OPERAND_NUM_WORDS+2).
- Sub-module: modinv_helper_store_addsub, a registered 32-bit add-with-carry and carry flop with init/enable. It is reusable by the other modinv helpers.
- Everything else is inline FSM and counter logic.

Test Plan:
- Basic correction-free case: q = P-256 prime, s = q+5 (s[8]=0), pulse ena.
  - Expect x = 5 in words 0..7, x_wren high 8 cycles.
  - Expect rdy back after 11 cycles and no COPY pass.
- Correction case: same q, s=5.
  - Expect a SUB pass that writes 5-q (mod 2^256), then a COPY that overwrites x with 5.
  - Expect x_wren high 16 cycles total and rdy after 20 cycles.
- Boundary s=q: expect x=0 and no COPY. Boundary s=q-1: expect a COPY with x=q-1.
- Top-word carry case: s = 2^256 + 3 (s[8]=1) with q=2^256-2^224+2^192+2^96-1.
  - Expect no borrow and x = s-q.
  - Expect q_addr never exceeds 7.
- Ignored start and async reset:
  - ena held high through SUB: expect exactly one operation, rdy low throughout.
  - rst_n low at SUB cnt=4: expect x_wren=0 and rdy=1 immediately.
  - A new ena afterwards then completes a correct run.
